// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and the control bits carried beside the pixel
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_DATA_LAT = 1;
  localparam bit DEF_SYNC_POL = 1'b0;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL      = vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic sof;
  } vga_ctl_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - renderer address/data loop plus the DAC-side colour, sync and blank pins
interface vga_if;
  import vga_pkg::*;

  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [23:0] vga_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic        frame_start;

  modport master (
    output h_addr, v_addr, vga_r, vga_g, vga_b, hsync, vsync, valid, frame_start,
    input  vga_data
  );

  modport slave (
    input  h_addr, v_addr, vga_r, vga_g, vga_b, hsync, vsync, valid, frame_start,
    output vga_data
  );

endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipe with synchronous clear
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - raster counters, renderer addressing and latency-matched DAC output stage
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int DATA_LAT = DEF_DATA_LAT,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input logic   i_clk,
  input logic   i_rst,
  vga_if.master io_vga
);

  localparam int HT   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_CW = $clog2(HT + 1);
  localparam int V_CW = $clog2(VT + 1);

  localparam logic [H_CW-1:0] H_LAST  = H_CW'(HT - 1);
  localparam logic [H_CW-1:0] H_ACT_E = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] H_SS    = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] H_SE    = H_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST  = V_CW'(VT - 1);
  localparam logic [V_CW-1:0] V_ACT_E = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] V_SS    = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] V_SE    = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CW-1:0] r_h_cnt;
  logic [V_CW-1:0] r_v_cnt;
  logic [23:0]     r_rgb;

  logic     w_h_vis;
  logic     w_v_vis;
  vga_ctl_t w_ctl_raw;
  vga_ctl_t w_ctl_dly;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_h_vis = (r_h_cnt < H_ACT_E);
  assign w_v_vis = (r_v_cnt < V_ACT_E);

  assign io_vga.h_addr = w_h_vis ? 10'(r_h_cnt) : 10'd0;
  assign io_vga.v_addr = w_v_vis ? 10'(r_v_cnt) : 10'd0;

  assign w_ctl_raw.act = w_h_vis & w_v_vis;
  assign w_ctl_raw.hs  = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
  assign w_ctl_raw.vs  = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
  assign w_ctl_raw.sof = (r_h_cnt == '0) && (r_v_cnt == '0);

  // One stage per renderer clock plus one for the colour register, so sync meets its pixel.
  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (DATA_LAT + 1)
  ) u_ctl_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (w_ctl_raw),
    .o_data (w_ctl_dly)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= io_vga.vga_data;
    end
  end

  assign io_vga.vga_r       = w_ctl_dly.act ? r_rgb[23:16] : 8'h00;
  assign io_vga.vga_g       = w_ctl_dly.act ? r_rgb[15:8]  : 8'h00;
  assign io_vga.vga_b       = w_ctl_dly.act ? r_rgb[7:0]   : 8'h00;
  assign io_vga.valid       = w_ctl_dly.act;
  assign io_vga.hsync       = w_ctl_dly.hs ~^ SYNC_POL;
  assign io_vga.vsync       = w_ctl_dly.vs ~^ SYNC_POL;
  assign io_vga.frame_start = w_ctl_dly.sof;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - full-size and shrunk-raster instances against an arithmetic raster model
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam bit SMALL = (g != 0);
    localparam int HA  = SMALL ? 16 : 640;
    localparam int HFP = SMALL ? 4  : 16;
    localparam int HS  = SMALL ? 6  : 96;
    localparam int HBP = SMALL ? 6  : 48;
    localparam int VA  = SMALL ? 12 : 480;
    localparam int VFP = SMALL ? 2  : 10;
    localparam int VS  = 2;
    localparam int VBP = SMALL ? 3  : 33;
    localparam int L   = (g == 2) ? 3 : (g == 3) ? 4 : 1;
    localparam bit POL = (g == 3);
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int F   = HT * VT;

    vga_if u_if ();

    vga_timing_ctrl #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .DATA_LAT (L),  .SYNC_POL (POL)
    ) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_vga (u_if)
    );

    int          n_cyc = 0;
    bit          armed = 1'b0;
    bit          rst_prev = 1'b0;
    logic [23:0] hist [5];
    logic [23:0] data_drv = '0;
    int          mode_drv = 0;
    bit          hs_prev, vs_prev, hs_seen, vs_seen, fs_seen;
    int          hs_fall, vs_fall, fs_last, val_cnt;

    initial u_if.vga_data = '0;

    always @(negedge clk) begin
      int pos, h, v, q, hq, vq;
      bit e_act, e_hs, e_vs, e_sof, hs_on, vs_on;
      logic [23:0] e_rgb;
      if (rst_prev) begin
        n_cyc = 0; armed = 1'b1;
        hs_prev = 0; vs_prev = 0; hs_seen = 0; vs_seen = 0; fs_seen = 0; val_cnt = 0;
      end else begin
        n_cyc = n_cyc + 1;
      end
      rst_prev = rst;
      if (armed) begin
        pos = n_cyc % F; h = pos % HT; v = pos / HT;
        q = 0; hq = 0; vq = 0;
        e_act = 0; e_hs = 0; e_vs = 0; e_sof = 0;
        if (n_cyc >= L + 1) begin
          q = (n_cyc - L - 1) % F; hq = q % HT; vq = q / HT;
          e_act = (hq < HA) && (vq < VA);
          e_hs  = (hq >= HA + HFP) && (hq < HA + HFP + HS);
          e_vs  = (vq >= VA + VFP) && (vq < VA + VFP + VS);
          e_sof = (q == 0);
        end
        e_rgb = !e_act ? 24'h0 : (mode_drv == 0) ? {hq[7:0], vq[7:0], 8'h5A} : data_drv;
        chk($sformatf("g%0d_pins n=%0d", g, n_cyc),
            longint'({u_if.h_addr, u_if.v_addr, u_if.vga_r, u_if.vga_g, u_if.vga_b,
                      u_if.hsync, u_if.vsync, u_if.valid, u_if.frame_start}),
            longint'({10'(h < HA ? h : 0), 10'(v < VA ? v : 0), e_rgb,
                      (e_hs ? POL : !POL), (e_vs ? POL : !POL), e_act, e_sof}));

        hs_on = (u_if.hsync == POL);
        if (hs_on && !hs_prev) begin
          if (!hs_seen) chk($sformatf("g%0d_hs_first", g), longint'(n_cyc), longint'(HA + HFP + L + 1));
          else          chk($sformatf("g%0d_hs_period", g), longint'(n_cyc - hs_fall), longint'(HT));
          hs_seen = 1; hs_fall = n_cyc;
        end
        if (!hs_on && hs_prev) chk($sformatf("g%0d_hs_width", g), longint'(n_cyc - hs_fall), longint'(HS));
        hs_prev = hs_on;

        vs_on = (u_if.vsync == POL);
        if (vs_on && !vs_prev) begin
          if (!vs_seen) chk($sformatf("g%0d_vs_first", g), longint'(n_cyc), longint'((VA + VFP) * HT + L + 1));
          else          chk($sformatf("g%0d_vs_period", g), longint'(n_cyc - vs_fall), longint'(F));
          vs_seen = 1; vs_fall = n_cyc;
        end
        if (!vs_on && vs_prev) chk($sformatf("g%0d_vs_width", g), longint'(n_cyc - vs_fall), longint'(VS * HT));
        vs_prev = vs_on;

        if (u_if.frame_start) begin
          if (!fs_seen) begin
            chk($sformatf("g%0d_fs_first", g), longint'(n_cyc), longint'(L + 1));
          end else begin
            chk($sformatf("g%0d_fs_period", g), longint'(n_cyc - fs_last), longint'(F));
            chk($sformatf("g%0d_valid_count", g), longint'(val_cnt), longint'(HA * VA));
          end
          fs_seen = 1; fs_last = n_cyc; val_cnt = 0;
        end
        if (u_if.valid) val_cnt++;
      end

      // Renderer model: address seen this cycle comes back L cycles later.
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = {u_if.h_addr[7:0], u_if.v_addr[7:0], 8'h5A};
      data_drv = (mode == 0) ? hist[L] : (mode == 1) ? 24'hFFFFFF : 24'($urandom);
      mode_drv = mode;
      u_if.vga_data = data_drv;
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    mode = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2500) @(posedge clk);
    #1 mode = 1;
    repeat (700) @(posedge clk);
    #1 mode = 2;
    repeat (700) @(posedge clk);
    #1 mode = 0;

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      if (gen_dut[1].n_cyc % 608 == 7 * 32 + 5) found = 1'b1;
    end
    chk("mid_reset_reached", longint'(found), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (1400) @(posedge clk);

    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(50, 900)) @(posedge clk);
      #1 rst = 1'b1;
      mode = $urandom_range(0, 2);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 rst = 1'b0;
    end
    #1 mode = 0;
    repeat (1400) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- VGA timing generator and output stage for the 640x480@60 display path.
- Sits upstream and downstream of the sprite renderer: drives h_addr/v_addr into the renderer, takes the 24-bit vga_data back, and drives RGB, sync and blanking to the DAC/connector.
- Aligns sync and blank with the renderer's registered pixel latency so colour and sync reach the pins on the same cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- DATA_LAT, 1, clocks from h_addr/v_addr to matching vga_data (range 1..4)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal), sole clock
- rst  in  1  synchronous active-high reset
- vga_data  in  24  pixel colour from renderer, {R,G,B} 8 bits each
- h_addr  out  10  current column to renderer
- v_addr  out  10  current row to renderer
- vga_r  out  8  red to DAC
- vga_g  out  8  green to DAC
- vga_b  out  8  blue to DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  high while the pixel on vga_r/g/b is visible (DAC blank_n)
- frame_start  out  1  one-cycle pulse, aligned with pixel (0,0) on the outputs

Behaviour:
- One clock domain. Reset is synchronous and active-high. No other resets.
- Counter sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1):
  - h_cnt increments every clock.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
- Region order within a line or frame: active, front porch, sync, back porch.
  - hs_raw = (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vs_raw uses the same rule on v_cnt.
  - act_raw = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Address outputs are combinational from the counters:
  - h_addr = h_cnt when h_cnt < H_ACTIVE, else 0.
  - v_addr = v_cnt when v_cnt < V_ACTIVE, else 0.
- Pipeline alignment:
  - Pixel addressed in cycle t appears on vga_data in cycle t+DATA_LAT.
  - vga_r/g/b are registered from vga_data, so colour for that pixel is on the outputs in cycle t+DATA_LAT+1.
  - act_raw, hs_raw, vs_raw and sof_raw (h_cnt=0 & v_cnt=0) pass through a DATA_LAT+1 stage register delay, so they land on the same cycle as the colour.
- Blanking: when the delayed active bit is 0, vga_r/g/b = 0 regardless of vga_data, and valid = 0.
- Sync polarity: hsync = delayed hs XNOR SYNC_POL; vsync uses the same rule. With SYNC_POL = 0 the idle level is 1.
- Reset values:
  - h_cnt = v_cnt = 0.
  - All delay stages cleared.
  - vga_r/g/b = 0, valid = 0, frame_start = 0.
  - hsync = vsync = inactive level (1 when SYNC_POL = 0).
  - h_addr = v_addr = 0.
- Reset mid-frame: the outputs above take their reset values on the next edge. Counting restarts at (0,0) on the first cycle after rst falls, with no partial-line glitch on the sync outputs.
- Reset behaviour for the first frame:
  - frame_start first pulses DATA_LAT+1 cycles after rst deasserts.
  - This is not DATA_LAT+1 cycles after the counters first reach (0,0).
  - The delayed sof bit held while in reset is masked.
- Period checks: frame = 420000 clocks; line = 800 clocks; hsync pulse = 96 clocks; vsync pulse = 2 lines (1600 clocks), asserted during lines 490..491.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END;
  - a packed struct vga_ctl_t {act, hs, vs, sof} that carries the control bits through the delay line.
- One sub-module, vga_delay_line:
  - parameterised width and depth (DEPTH = DATA_LAT+1);
  - synchronous clear on rst;
  - instantiated once for vga_ctl_t.
- The counters and output register stay in the top module.

Test Plan:
- Reset and hsync timing: hold rst 5 cycles, then release.
  - Expect hsync = 1, valid = 0 and RGB = 0 during reset.
  - First hsync falling edge exactly 656+DATA_LAT+1 cycles after release.
  - hsync stays low 96 cycles, and the period is 800.
- Frame timing: run 2 full frames.
  - vsync low for 1600 consecutive clocks starting at line 490.
  - frame_start pulses every 420000 clocks.
  - valid is high for exactly 307200 clocks per frame.
- Alignment: bench model renders vga_data = {h_addr[7:0], v_addr[7:0], 8'h5A}, registered DATA_LAT deep.
  - Every cycle with valid = 1 must show vga_r = column[7:0] and vga_g = row[7:0] for the matching counters.
  - Repeat with DATA_LAT = 1 and DATA_LAT = 3.
- Blanking override: drive vga_data = 24'hFFFFFF constantly.
  - Whenever valid = 0, vga_r/g/b must be 0.
  - h_addr = 0 when h_cnt ≥ 640; v_addr = 0 on lines 480..524.
- Reset mid-frame: assert rst for 1 cycle at line 300, column 100.
  - Outputs take reset values on the next edge.
  - The next frame_start comes DATA_LAT+1 cycles after release.
  - The following frame_start comes 420000 cycles after that.
- Polarity: SYNC_POL = 1.
  - Syncs idle at 0 and pulse high with the same timing as the SYNC_POL = 0 runs.
